// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module  : muldiv_unit_pkg
// Brief   : RV32M funct3 codes, multiply/divide FSM states and negate helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        FAST = 2'd3
    } state_t;

    function automatic logic [31:0] cneg32(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative RV32M multiply/divide unit (shift-add / restoring div).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import muldiv_unit_pkg::*;

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       acc_q;
    logic [31:0]       opb_q;
    logic              neg_q;
    logic              rneg_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       result_q;

    // Operand capture: magnitudes, signs and special-case detection.
    logic        w_a_signed, w_b_signed, w_sa, w_sb;
    logic [31:0] w_amag, w_bmag;
    logic        w_div0, w_ovf;
    logic [31:0] w_fast_res;

    always_comb begin
        w_a_signed = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
        w_b_signed = w_a_signed && (op != OP_MULHSU);
        w_sa       = w_a_signed & rs1_data[31];
        w_sb       = w_b_signed & rs2_data[31];
        w_amag     = cneg32(rs1_data, w_sa);
        w_bmag     = cneg32(rs2_data, w_sb);
        w_div0     = op[2] && (rs2_data == 32'd0);
        w_ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                     (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
        w_fast_res = 32'd0;
        if (w_div0)
            w_fast_res = op[1] ? rs1_data : 32'hFFFF_FFFF;
        else if (w_ovf)
            w_fast_res = op[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration: multiply keeps the multiplier in acc[31:0], divide keeps
    // the dividend there and shifts quotient bits in from the right.
    logic [32:0] w_sum, w_rem, w_diff;
    logic [63:0] w_acc_d;
    logic [31:0] w_plo, w_phi, w_res;

    always_comb begin
        w_sum  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
        w_rem  = {acc_q[63:32], acc_q[31]};
        w_diff = w_rem - {1'b0, opb_q};
        if (op_q[2])
            w_acc_d = w_diff[32] ? {w_rem[31:0], acc_q[30:0], 1'b0}
                                 : {w_diff[31:0], acc_q[30:0], 1'b1};
        else
            w_acc_d = acc_q[0] ? {w_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

        // 64-bit negate split into halves: the high half borrows unless lo is 0.
        w_plo = cneg32(w_acc_d[31:0], neg_q);
        w_phi = cneg32(w_acc_d[63:32], neg_q) - {31'd0, neg_q & (|w_acc_d[31:0])};
        case (op_q)
            OP_MUL, OP_DIV, OP_DIVU:      w_res = w_plo;
            OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_phi;
            default:                      w_res = cneg32(w_acc_d[63:32], rneg_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            cnt_q    <= '0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        op_q   <= op;
                        neg_q  <= w_sa ^ w_sb;
                        rneg_q <= w_sa;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            state_q  <= FAST;
                            done_q   <= 1'b1;
                            result_q <= w_fast_res;
                        end else begin
                            state_q <= CALC;
                            acc_q   <= {32'd0, op[2] ? w_amag : w_bmag};
                            opb_q   <= op[2] ? w_bmag : w_amag;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= w_acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            state_q  <= FIN;
                            done_q   <= 1'b1;
                            result_q <= w_res;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench for muldiv_unit against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        r  = 32'd0;
        case (f)
            OP_MUL:    begin p = sa * sb;          r = p[31:0];  end
            OP_MULH:   begin p = sa * sb;          r = p[63:32]; end
            OP_MULHSU: begin p = sa * $signed(ub); r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub;          r = p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            OP_DIVU: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else r = a / b;
            end
            OP_REM: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) ||
               ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Launch in the current cycle (cycle 0); a non-zero stray injects a start
    // pulse with junk operands in that cycle of the running operation.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int stray);
        logic [31:0] exp;
        int          lat;
        exp = model(f, a, b);
        lat = special(f, a, b) ? 1 : 33;
        op = f; rs1_data = a; rs2_data = b; start = 1'b1;
        step();
        start = 1'b0; op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        for (int c = 1; c <= lat; c++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done"}, 32'(done), 32'(c == lat));
            if (c == lat) check({tag, "_result"}, result, exp);
            start = (c == stray);
            if (c == stray) begin
                op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            end
            step();
        end
        start = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b0; start = 1'b0; flush = 1'b0;
        op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (2) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b1;
        step();

        run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, "mul_7_m3", 0);
        run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, "mulh", 0);
        run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu", 0);
        run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu", 0);
        run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         "div_m7_2", 0);
        run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         "rem_m7_2", 0);
        run_op(OP_DIVU,   32'd100,        32'd7,         "divu", 0);
        run_op(OP_REMU,   32'd100,        32'd7,         "remu", 0);
        run_op(OP_DIV,    32'd5,          32'd0,         "div_by0", 0);
        run_op(OP_REMU,   32'd5,          32'd0,         "remu_by0", 0);
        run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf", 0);
        run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf", 0);

        // Flush of a running DIVU in cycle 10.
        run_op(OP_MUL, 32'd1234, 32'd5678, "pre_flush", 0);
        held = result;
        op = OP_DIVU; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, held);
        for (int c = 0; c < 30; c++) begin
            check("flush_no_done", 32'(done), 32'd0);
            step();
        end
        check("flush_result_late", result, held);

        // Flush together with start in IDLE drops the start.
        op = OP_DIVU; rs1_data = 32'd9; rs2_data = 32'd0; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        check("flush_start_done", 32'(done), 32'd0);
        check("flush_start_result", result, held);

        run_op(OP_MUL, 32'h0001_2345, 32'hFFFF_0F0F, "stray_start", 5);

        // Reset asserted in cycle 15 of a running DIV.
        op = OP_DIV; rs1_data = 32'd12345; rs2_data = 32'd17; start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        step();
        reset = 1'b1;
        step();
        run_op(OP_MUL, 32'd3, 32'd4, "mul_after_rst", 0);

        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 6 == 5) rb = 32'($urandom_range(1, 20));
            run_op(rf, ra, rb, $sformatf("rand%0d_op%0d", i, rf), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
